dram_responder: RTL and testbench

Synthesizable DRAM-side responder for the five-channel AXI-lite-style bus (AR/R/AW/W/B) that the Program controller drives. It holds DEPTH 64-bit pattern records at byte address BASE + 8·no. It answers one read or one write at a time, with programmable latency, and returns OKAY or SLVERR. It replaces the behavioural pseudo-DRAM at the bottom of the datapath, so the controller can be simulated and synthesized against a real slave.

---
 rtl/dram_responder.sv | 175 +++++++++++++++++
 tb/tb_dram_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// Single-port DRAM-side responder for the AR/R/AW/W/B bus: one transaction at a time,
// fixed latency (or LFSR-jittered latency when DRAM_RESP_RANDLAT_EN is defined).
module dram_responder #(
  parameter int unsigned DEPTH  = 256,
  parameter logic [16:0] BASE   = 17'h1_0000,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY
);

  localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW      = 5;
  localparam int unsigned LimitAddr = 32'(BASE) + 8 * DEPTH;
  localparam logic [CntW-1:0] RdLoad = CntW'(RD_LAT - 1);
  localparam logic [CntW-1:0] WrLoad = CntW'(WR_LAT - 1);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StArAck, StRdWait, StRSend, StAwAck, StWWait, StWrWait, StBSend
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [16:0]     addr_q, addr_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [63:0]     r_data_q, r_data_d;
  logic [1:0]      r_resp_q, r_resp_d;
  logic [1:0]      b_resp_q, b_resp_d;
  logic            mem_we;
  logic [CntW-1:0] extra;

  logic [63:0]     mem [DEPTH];

  logic [31:0]     addr_ext;
  logic            addr_legal;
  logic [IdxW-1:0] idx;

  assign addr_ext   = 32'(addr_q);
  assign addr_legal = (addr_q[2:0] == 3'b000) && (addr_ext >= 32'(BASE)) &&
                      (addr_ext < LimitAddr);
  assign idx        = IdxW'((addr_ext - 32'(BASE)) >> 3);

`ifdef DRAM_RESP_RANDLAT_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; free-running so jitter differs per transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign extra = {2'b00, lfsr_q[2:0]};
`else
  assign extra = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    b_resp_d = b_resp_q;
    mem_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Read has priority; a concurrent AW stays pending for a later idle cycle.
        if (AR_VALID) begin
          addr_d  = AR_ADDR;
          state_d = StArAck;
        end else if (AW_VALID) begin
          addr_d  = AW_ADDR;
          state_d = StAwAck;
        end
      end
      StArAck: begin
        cnt_d   = RdLoad + extra;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (cnt_q == '0) begin
          r_data_d = addr_legal ? mem[idx] : 64'd0;
          r_resp_d = addr_legal ? RespOkay : RespSlverr;
          state_d  = StRSend;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRSend: begin
        if (R_READY) state_d = StIdle;
      end
      StAwAck: begin
        state_d = StWWait;
      end
      StWWait: begin
        if (W_VALID) begin
          wdata_d = W_DATA;
          cnt_d   = WrLoad + extra;
          state_d = StWrWait;
        end
      end
      StWrWait: begin
        if (cnt_q == '0) begin
          mem_we   = addr_legal;
          b_resp_d = addr_legal ? RespOkay : RespSlverr;
          state_d  = StBSend;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StBSend: begin
        if (B_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      r_data_q <= '0;
      r_resp_q <= '0;
      b_resp_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      r_data_q <= r_data_d;
      r_resp_q <= r_resp_d;
      b_resp_q <= b_resp_d;
    end
  end

  // Array is never reset; a reset on the commit edge discards the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[idx] <= wdata_q;
  end

  assign AR_READY = (state_q == StArAck);
  assign AW_READY = (state_q == StAwAck);
  assign W_READY  = (state_q == StWWait);
  assign R_VALID  = (state_q == StRSend);
  assign B_VALID  = (state_q == StBSend);
  assign R_DATA   = R_VALID ? r_data_q : 64'd0;
  assign R_RESP   = R_VALID ? r_resp_q : 2'b00;
  assign B_RESP   = B_VALID ? b_resp_q : 2'b00;

endmodule

// File: tb/tb_dram_responder.sv
// Directed self-checking bench for dram_responder (default parameters).
// Latency checks widen to the jitter window when DRAM_RESP_RANDLAT_EN is defined.
module tb_dram_responder;

  localparam int RdLat = 2;
  localparam int WrLat = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        AR_VALID, AR_READY, R_VALID, R_READY;
  logic [16:0] AR_ADDR, AW_ADDR;
  logic [63:0] R_DATA, W_DATA;
  logic [1:0]  R_RESP, B_RESP;
  logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dram_responder dut (
    .clk      (clk),
    .rst      (rst),
    .AR_VALID (AR_VALID),
    .AR_ADDR  (AR_ADDR),
    .AR_READY (AR_READY),
    .R_VALID  (R_VALID),
    .R_DATA   (R_DATA),
    .R_RESP   (R_RESP),
    .R_READY  (R_READY),
    .AW_VALID (AW_VALID),
    .AW_ADDR  (AW_ADDR),
    .AW_READY (AW_READY),
    .W_VALID  (W_VALID),
    .W_DATA   (W_DATA),
    .W_READY  (W_READY),
    .B_VALID  (B_VALID),
    .B_RESP   (B_RESP),
    .B_READY  (B_READY)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rd_lat(input string tag, input int lat);
`ifdef DRAM_RESP_RANDLAT_EN
    check_eq(tag, 64'((lat >= RdLat + 1) && (lat <= RdLat + 8)), 64'd1);
`else
    check_eq(tag, 64'(lat), 64'(RdLat + 1));
`endif
  endtask

  task automatic check_wr_lat(input string tag, input int lat);
`ifdef DRAM_RESP_RANDLAT_EN
    check_eq(tag, 64'((lat >= WrLat) && (lat <= WrLat + 7)), 64'd1);
`else
    check_eq(tag, 64'(lat), 64'(WrLat));
`endif
  endtask

  // Full write transaction; lat counts cycles from the W handshake to B_VALID.
  task automatic do_write(input logic [16:0] a, input logic [63:0] d,
                          output logic [1:0] resp, output int lat);
    bit ok, hs, prev_wready;
    int wl;
    ok = 0; hs = 0; wl = 0; lat = 0; resp = 2'b11;
    AW_ADDR = a; AW_VALID = 1'b1; W_DATA = d; W_VALID = 1'b1; B_READY = 1'b1;
    for (int n = 0; n < 60 && !ok; n++) begin
      prev_wready = W_READY;
      tick();
      if (AW_READY) AW_VALID = 1'b0;
      if (hs) wl++;
      if (prev_wready && !hs) begin
        hs = 1;
        W_VALID = 1'b0;
      end
      if (B_VALID) begin
        ok = 1;
        lat = wl;
        resp = B_RESP;
      end
    end
    AW_VALID = 1'b0;
    W_VALID = 1'b0;
    check_eq("wr_done", 64'(ok), 64'd1);
    if (ok) begin
      tick();
      check_eq("b_drop", 64'(B_VALID), 64'd0);
    end
    B_READY = 1'b0;
  endtask

  // Full read; lat counts cycles from the AR_VALID sample edge to the first R_VALID.
  task automatic do_read(input logic [16:0] a, input int hold, output logic [63:0] d,
                         output logic [1:0] resp, output int lat);
    bit ok;
    ok = 0; lat = 0; d = '0; resp = 2'b11;
    AR_ADDR = a; AR_VALID = 1'b1; R_READY = (hold == 0);
    for (int n = 0; n < 60 && !ok; n++) begin
      tick();
      if (AR_READY) AR_VALID = 1'b0;
      if (R_VALID) begin
        ok = 1;
        lat = n;
        d = R_DATA;
        resp = R_RESP;
      end
    end
    AR_VALID = 1'b0;
    check_eq("rd_done", 64'(ok), 64'd1);
    if (ok) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        check_eq("hold_valid", 64'(R_VALID), 64'd1);
        check_eq("hold_data", R_DATA, d);
      end
      R_READY = 1'b1;
      tick();
      R_READY = 1'b0;
      check_eq("r_drop", 64'(R_VALID), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  resp;
    int          lat;
    bit          flag, done;
    logic [63:0] pat;
    logic [63:0] rec0;

    pat  = 64'h3456_00C7_89AB_C01F;
    rec0 = 64'hA5A5_0000_1111_2222;
    rst = 1'b1;
    AR_VALID = 0; AR_ADDR = '0; R_READY = 0;
    AW_VALID = 0; AW_ADDR = '0; W_VALID = 0; W_DATA = '0; B_READY = 0;
    repeat (3) tick();
    check_eq("rst_ctl", 64'({AR_READY, AW_READY, W_READY, R_VALID, B_VALID, R_RESP, B_RESP}),
             64'd0);
    check_eq("rst_rdata", R_DATA, 64'd0);
    rst = 1'b0;
    tick();

    // Basic write/read round trip, plus latency.
    do_write(17'h1_0000, rec0, resp, lat);
    check_eq("w0_resp", 64'(resp), 64'd0);
    do_write(17'h1_0008, pat, resp, lat);
    check_eq("w1_resp", 64'(resp), 64'd0);
    check_wr_lat("w1_lat", lat);
    do_read(17'h1_0008, 0, d, resp, lat);
    check_eq("r1_data", d, pat);
    check_eq("r1_resp", 64'(resp), 64'd0);
    check_rd_lat("r1_lat", lat);

    // Last legal record.
    do_write(17'h1_07F8, 64'h0123_4567_89AB_CDEF, resp, lat);
    check_eq("wlast_resp", 64'(resp), 64'd0);
    do_read(17'h1_07F8, 0, d, resp, lat);
    check_eq("rlast_data", d, 64'h0123_4567_89AB_CDEF);
    check_eq("rlast_resp", 64'(resp), 64'd0);

    // Illegal addresses.
    do_read(17'h1_0004, 0, d, resp, lat);
    check_eq("mis_resp", 64'(resp), 64'd2);
    check_eq("mis_data", d, 64'd0);
    do_read(17'h1_0800, 0, d, resp, lat);
    check_eq("oob_resp", 64'(resp), 64'd2);
    check_eq("oob_data", d, 64'd0);
    do_write(17'h0_FFF8, 64'hDEAD_DEAD_DEAD_DEAD, resp, lat);
    check_eq("wbad_resp", 64'(resp), 64'd2);
    do_read(17'h1_0000, 0, d, resp, lat);
    check_eq("r0_unchanged", d, rec0);

    // AR and AW together: read first, write only after the R handshake.
    AR_ADDR = 17'h1_0000; AR_VALID = 1'b1;
    AW_ADDR = 17'h1_0018; AW_VALID = 1'b1;
    W_DATA = 64'h0BAD_F00D_3333_0003; W_VALID = 1'b1;
    R_READY = 1'b1; B_READY = 1'b1;
    tick();
    check_eq("both_ar_first", 64'({AR_READY, AW_READY}), 64'd2);
    AR_VALID = 1'b0;
    flag = 0; done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      if (AW_READY) flag = 1;
      if (R_VALID) begin
        done = 1;
        d = R_DATA;
      end
    end
    check_eq("both_r_seen", 64'(done), 64'd1);
    check_eq("both_r_data", d, rec0);
    check_eq("both_aw_wait", 64'(flag), 64'd0);
    tick();
    R_READY = 1'b0;
    check_eq("both_idle_gap", 64'(AW_READY), 64'd0);
    tick();
    check_eq("both_aw_after", 64'(AW_READY), 64'd1);
    AW_VALID = 1'b0;
    done = 0; resp = 2'b11;
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      if (B_VALID) begin
        done = 1;
        resp = B_RESP;
      end
    end
    W_VALID = 1'b0;
    check_eq("both_b_seen", 64'(done), 64'd1);
    check_eq("both_b_resp", 64'(resp), 64'd0);
    tick();
    B_READY = 1'b0;
    do_read(17'h1_0018, 0, d, resp, lat);
    check_eq("both_w_data", d, 64'h0BAD_F00D_3333_0003);

    // Backpressure on R for 5 cycles, then no second beat.
    do_read(17'h1_0008, 5, d, resp, lat);
    check_eq("hold_first", d, pat);
    tick();
    check_eq("no_second_beat", 64'(R_VALID), 64'd0);

    // Reset during WR_WAIT discards the write.
    do_write(17'h1_0038, 64'hDEAD_BEEF_0000_0007, resp, lat);
    check_eq("w7_resp", 64'(resp), 64'd0);
    AW_ADDR = 17'h1_0038; AW_VALID = 1'b1; W_DATA = 64'hFFFF; W_VALID = 1'b1; B_READY = 1'b0;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      flag = W_READY;
      tick();
      if (AW_READY) AW_VALID = 1'b0;
      if (flag) done = 1;
    end
    check_eq("abort_hs", 64'(done), 64'd1);
    AW_VALID = 1'b0; W_VALID = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_ctl", 64'({AR_READY, AW_READY, W_READY, R_VALID, B_VALID, R_RESP, B_RESP}),
             64'd0);
    check_eq("abort_rdata", R_DATA, 64'd0);
    B_READY = 1'b1;
    flag = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (B_VALID) flag = 1;
    end
    B_READY = 1'b0;
    check_eq("abort_no_b", 64'(flag), 64'd0);
    do_read(17'h1_0038, 0, d, resp, lat);
    check_eq("r7_prior", d, 64'hDEAD_BEEF_0000_0007);

`ifdef DRAM_RESP_RANDLAT_EN
    for (int k = 0; k < 4; k++) begin
      do_write(17'h1_0100 + 17'(8 * k), 64'hC0DE_0000_0000_0000 | 64'(k), resp, lat);
      check_wr_lat("rand_wlat", lat);
    end
    for (int i = 0; i < 20; i++) begin
      do_read(17'h1_0100 + 17'(8 * (i % 4)), 0, d, resp, lat);
      check_rd_lat("rand_rlat", lat);
      check_eq("rand_data", d, 64'hC0DE_0000_0000_0000 | 64'(i % 4));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
